// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional build macro PC_MISALIGN_TRAP_EN is consumed by next_pc_sel and pc_sequencer.
package pc_seq_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } redirect_t;

    // Clears the byte-offset bits so a target is always word aligned.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jump_reg > jump > branch_taken > sequential.
// With PC_MISALIGN_TRAP_EN defined it also flags a jump-register to a non-word address.
module next_pc_sel
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus4,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] jr_addr,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [PC_W-1:0] next_pc
);

    redirect_t       sel;
    logic [PC_W-1:0] branch_disp;

    // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        sel = SEQ;
        if (jump_reg) begin
            sel = JR;
        end else if (jump) begin
            sel = J;
        end else if (branch_taken) begin
            sel = BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            JR:      next_pc = word_align(jr_addr);
            J:       next_pc = {pc_plus4[31:28], jump_target, 2'b00};
            BR:      next_pc = pc_plus4 + branch_disp;
            default: next_pc = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = jump_reg && (jr_addr[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: IDLE -> FETCH (req/ack) -> EXEC -> FETCH ..., HALTED until reset.
// Optional build macro PC_MISALIGN_TRAP_EN adds the sticky misalign_err output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO_JR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    input  logic        halt,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] next_pc;
    logic            jr_zero;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign;
    logic            err_reg, err_next;
`endif

    assign pc_plus4 = pc_reg + PC_W'(INSTR_BYTES);
    assign jr_zero  = (word_align(jr_addr) == '0);

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign      (misalign),
`endif
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
`ifdef PC_MISALIGN_TRAP_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
`ifdef PC_MISALIGN_TRAP_EN
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
`ifdef PC_MISALIGN_TRAP_EN
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE:  state_next = FETCH;
            FETCH: if (imem_ack) state_next = EXEC;
            EXEC: begin
                // A stalled EXEC ignores every redirect and halt input.
                if (!stall) begin
                    if (halt) begin
                        state_next = HALTED;
`ifdef PC_MISALIGN_TRAP_EN
                    end else if (misalign) begin
                        state_next = HALTED;
                        err_next   = 1'b1;
`endif
                    end else if (HALT_ON_ZERO_JR && jump_reg && jr_zero) begin
                        state_next = HALTED;
                    end else begin
                        pc_next    = next_pc;
                        state_next = FETCH;
                    end
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == EXEC);
    assign halted      = (state_reg == HALTED);
    assign pc          = pc_reg;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_err = err_reg;
`endif

endmodule
